// File: rtl/prog_loader.sv
// prog_loader: boot loader for the instruction memory. It holds the processor in
// reset, receives a byte stream (16-bit word count, payload words, XOR checksum),
// writes the words into the instruction memory and, if the checksum is good,
// releases the processor.
module prog_loader #(
  parameter int unsigned MINSTS  = 64,
  parameter int unsigned MINSTW  = $clog2(MINSTS),
  parameter int unsigned NBINST  = 14,
  parameter int unsigned AUTORUN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              im_wr,
  output logic [MINSTW-1:0] im_addr,
  output logic [NBINST-1:0] im_data,
  output logic              proc_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [MINSTW:0]   wcount
);

  localparam int unsigned NBYTES = (NBINST + 7) / 8;
  localparam int unsigned WW     = NBYTES * 8;
  localparam int unsigned BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    StIdle, StHdrHi, StHdrLo, StData, StChk, StRun, StErr
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         n_q, n_d;
  logic [7:0]          xr_q, xr_d;
  logic [WW-1:0]       word_q, word_d;
  logic [BCW-1:0]      bcnt_q, bcnt_d;
  logic [MINSTW:0]     wcount_q, wcount_d;
  logic                im_wr_q, im_wr_d;
  logic [MINSTW-1:0]   im_addr_q, im_addr_d;
  logic [NBINST-1:0]   im_data_q, im_data_d;
  logic                s_ready_q, s_ready_d;
  logic                proc_rst_q, proc_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept;
  logic [WW+7:0]       word_cat;
  logic [15:0]         n_full;
  logic [MINSTW:0]     wcount_inc;

  // Next-state and registered-output computation for the loader FSM.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    xr_d       = xr_q;
    word_d     = word_q;
    bcnt_d     = bcnt_q;
    wcount_d   = wcount_q;
    im_wr_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_data_d  = im_data_q;
    proc_rst_d = proc_rst_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;

    // A load_req cycle never accepts a byte, so an abort cannot complete a word.
    accept     = s_valid && s_ready_q && !load_req;
    word_cat   = {word_q, s_data};
    n_full     = {n_q[15:8], s_data};
    wcount_inc = wcount_q + 1'b1;

    if (load_req) begin
      state_d    = StHdrHi;
      xr_d       = 8'h00;
      wcount_d   = '0;
      bcnt_d     = '0;
      word_d     = '0;
      err_d      = 1'b0;
      done_d     = 1'b0;
      busy_d     = 1'b1;
      proc_rst_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          proc_rst_d = 1'b1;
          done_d     = 1'b0;
        end
        StHdrHi: begin
          if (accept) begin
            n_d[15:8] = s_data;
            xr_d      = xr_q ^ s_data;
            state_d   = StHdrLo;
          end
        end
        StHdrLo: begin
          if (accept) begin
            n_d  = n_full;
            xr_d = xr_q ^ s_data;
            if (n_full > 16'(MINSTS)) begin
              state_d    = StErr;
              err_d      = 1'b1;
              busy_d     = 1'b0;
              done_d     = 1'b0;
              proc_rst_d = 1'b1;
            end else if (n_full == 16'd0) begin
              state_d = StChk;
            end else begin
              state_d = StData;
            end
          end
        end
        StData: begin
          if (accept) begin
            xr_d   = xr_q ^ s_data;
            word_d = word_cat[WW-1:0];
            if (bcnt_q == BCW'(NBYTES - 1)) begin
              // Word complete: write it next cycle and advance the word count.
              bcnt_d    = '0;
              im_wr_d   = 1'b1;
              im_addr_d = wcount_q[MINSTW-1:0];
              im_data_d = word_cat[NBINST-1:0];
              wcount_d  = wcount_inc;
              if (16'(wcount_inc) == n_q) begin
                state_d = StChk;
              end
            end else begin
              bcnt_d = bcnt_q + BCW'(1);
            end
          end
        end
        StChk: begin
          if (accept) begin
            xr_d   = xr_q ^ s_data;
            busy_d = 1'b0;
            if ((xr_q ^ s_data) == 8'h00) begin
              state_d    = StRun;
              proc_rst_d = 1'b0;
              done_d     = 1'b1;
            end else begin
              state_d    = StErr;
              err_d      = 1'b1;
              proc_rst_d = 1'b1;
              done_d     = 1'b0;
            end
          end
        end
        StRun: begin
          proc_rst_d = 1'b0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
        end
        StErr: begin
          proc_rst_d = 1'b1;
          err_d      = 1'b1;
          busy_d     = 1'b0;
          done_d     = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end

    s_ready_d = (state_d == StHdrHi) || (state_d == StHdrLo) ||
                (state_d == StData)  || (state_d == StChk);
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= (AUTORUN != 0) ? StRun : StIdle;
      n_q        <= 16'h0000;
      xr_q       <= 8'h00;
      word_q     <= '0;
      bcnt_q     <= '0;
      wcount_q   <= '0;
      im_wr_q    <= 1'b0;
      im_addr_q  <= '0;
      im_data_q  <= '0;
      s_ready_q  <= 1'b0;
      proc_rst_q <= (AUTORUN == 0);
      busy_q     <= 1'b0;
      done_q     <= (AUTORUN != 0);
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      xr_q       <= xr_d;
      word_q     <= word_d;
      bcnt_q     <= bcnt_d;
      wcount_q   <= wcount_d;
      im_wr_q    <= im_wr_d;
      im_addr_q  <= im_addr_d;
      im_data_q  <= im_data_d;
      s_ready_q  <= s_ready_d;
      proc_rst_q <= proc_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign im_wr    = im_wr_q;
  assign im_addr  = im_addr_q;
  assign im_data  = im_data_q;
  assign proc_rst = proc_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign wcount   = wcount_q;

endmodule
